// File: rtl/gray_ptr_fifo.sv
// Single-clock FIFO with Gray-coded pointers crossed through 2-flop synchronizers,
// so flag latency matches the dual-clock version and the core can later be split.
module gray_ptr_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RESERVE    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  has_data
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);
    localparam logic [PW:0] RSV_W   = (PW+1)'(RESERVE);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Per-side reset release: shifts in ones, so each side leaves reset on the 2nd edge.
    logic [1:0] wr_rls_q, rd_rls_q;
    logic       wr_rst, rd_rst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_rls_q <= '0;
            rd_rls_q <= '0;
        end else begin
            wr_rls_q <= {wr_rls_q[0], 1'b1};
            rd_rls_q <= {rd_rls_q[0], 1'b1};
        end
    end

    assign wr_rst = ~wr_rls_q[1];
    assign rd_rst = ~rd_rls_q[1];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_gray_q, wr_gray_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, rd_gray_q, rd_gray_d;
    logic [PW-1:0] wq1_q, wq2_q, rq1_q, rq2_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic          wr_fire, rd_fire;
    logic [PW-1:0] used;
    logic [PW:0]   free_cnt;

    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_gray, rd_ptr_gray;
    assign wr_ptr      = wr_ptr_q;
    assign rd_ptr      = rd_ptr_q;
    assign wr_ptr_gray = wr_gray_q;
    assign rd_ptr_gray = rd_gray_q;

    assign wr_fire = wr_en && !full && !wr_rst;
    assign rd_fire = rd_en && !empty && !rd_rst;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + (wr_fire ? PW'(1) : PW'(0));
        wr_gray_d = wr_ptr_d ^ (wr_ptr_d >> 1);
        rd_ptr_d  = rd_ptr_q + (rd_fire ? PW'(1) : PW'(0));
        rd_gray_d = rd_ptr_d ^ (rd_ptr_d >> 1);
    end

    // Full uses the synchronized read pointer, so it stays pessimistic until the read is seen.
    always_comb begin
        used     = wr_ptr_q - gray2bin(rq2_q);
        free_cnt = DEPTH_W - {1'b0, used};
        full     = (free_cnt <= RSV_W);
    end

    assign empty    = (rd_gray_q == wq2_q);
    assign has_data = ~empty;
    assign rd_data  = rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            wr_gray_q <= '0;
            rd_ptr_q  <= '0;
            rd_gray_q <= '0;
            wq1_q     <= '0;
            wq2_q     <= '0;
            rq1_q     <= '0;
            rq2_q     <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            wr_gray_q <= wr_gray_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_gray_q <= rd_gray_d;
            wq1_q     <= wr_gray_q;
            wq2_q     <= wq1_q;
            rq1_q     <= rd_gray_q;
            rq2_q     <= rq1_q;
            if (rd_fire) begin
                rd_data_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_gray_ptr_fifo.sv
// Directed bench for gray_ptr_fifo at DEPTH=4: ordering, flag timing, Gray steps, reset.
module tb_gray_ptr_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       full, empty, has_data;

    int vecs = 0;
    int errs = 0;
    int widx = 0;
    int ridx = 0;

    gray_ptr_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .RESERVE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .has_data(has_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        while (full && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            chk("wr_wait_full", 32'(full), 32'd0);
        end else begin
            wr_en   = 1'b1;
            wr_data = d;
            tick();
            wr_en   = 1'b0;
            widx++;
        end
    endtask

    task automatic pop(input logic [7:0] exp, input string tag);
        int n = 0;
        while (empty && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            chk("rd_wait_empty", 32'(empty), 32'd0);
        end else begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            chk(tag, 32'(rd_data), 32'(exp));
            ridx++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] prev_g, b;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_has_data", 32'(has_data), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_wr_ptr", 32'(dut.wr_ptr), 32'd0);
        chk("rst_wr_rst", 32'(dut.wr_rst), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rls_edge1_wr_rst", 32'(dut.wr_rst), 32'd1);
        chk("rls_edge1_rd_rst", 32'(dut.rd_rst), 32'd1);
        tick();
        chk("rls_edge2_wr_rst", 32'(dut.wr_rst), 32'd0);
        chk("rls_edge2_rd_rst", 32'(dut.rd_rst), 32'd0);

        // Empty deasserts two edges after the first write
        wr_en = 1'b1; wr_data = 8'd0; tick(); wr_en = 1'b0; widx++;
        chk("empty_lat_e0", 32'(empty), 32'd1);
        tick();
        chk("empty_lat_e1", 32'(empty), 32'd1);
        tick();
        chk("empty_lat_e2", 32'(empty), 32'd0);
        pop(8'd0, "first_word");
        chk("empty_after_last", 32'(empty), 32'd1);

        // Fill/drain x10: data continues from write index 1
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 4; k++) push(8'(widx));
            for (int k = 0; k < 4; k++) pop(8'(ridx), "fill_drain");
        end
        chk("fill_drain_empty", 32'(empty), 32'd1);

        // Write 2 / read 2 x20
        for (int r = 0; r < 20; r++) begin
            push(8'(widx)); push(8'(widx));
            pop(8'(ridx), "w2r2"); pop(8'(ridx), "w2r2");
        end
        chk("w2r2_rd_ptr", 32'(dut.rd_ptr), 32'(ridx % 8));
        chk("w2r2_wr_ptr", 32'(dut.wr_ptr), 32'(widx % 8));

        // Gray pointer steps by exactly one bit per write, including wraps
        for (int k = 0; k < 16; k++) begin
            prev_g = dut.wr_ptr_gray;
            push(8'(widx));
            chk("gray_step", 32'($countones(prev_g ^ dut.wr_ptr_gray)), 32'd1);
            b = 3'(widx % 8);
            chk("gray_code", 32'(dut.wr_ptr_gray), 32'(b ^ (b >> 1)));
            pop(8'(ridx), "gray_rd");
        end

        // Fill until full, hold, drop a fifth write
        repeat (4) tick();
        for (int k = 0; k < 3; k++) push(8'(8'h40 + k));
        chk("full_at_3", 32'(full), 32'd0);
        push(8'h43);
        chk("full_at_4", 32'(full), 32'd1);
        wr_en = 1'b1; wr_data = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("full_hold", 32'(full), 32'd1);
        end
        wr_en = 1'b0;
        chk("full_drop_ptr", 32'(dut.wr_ptr), 32'(widx % 8));
        for (int k = 0; k < 4; k++) pop(8'(8'h40 + k), "full_drain");
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_has_data", 32'(has_data), 32'd0);
        repeat (3) tick();
        chk("drain_still_empty", 32'(empty), 32'd1);

        // Concurrent producer/consumer of 0..99
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    push(8'(i));
                    if (i % 7 == 3) tick();
                end
            end
            begin
                for (int j = 0; j < 100; j++) begin
                    pop(8'(j), "concurrent");
                    if (j % 5 == 2) tick();
                end
            end
        join
        repeat (3) tick();
        chk("conc_empty", 32'(empty), 32'd1);

        // Mid-operation reset with 3 words held
        push(8'h11); push(8'h22); push(8'h33);
        repeat (3) tick();
        chk("pre_rst_has_data", 32'(has_data), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_has_data", 32'(has_data), 32'd0);
        chk("mid_rst_wr_ptr", 32'(dut.wr_ptr), 32'd0);
        chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        push(8'hA5);
        pop(8'hA5, "post_rst_word");
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
